// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, types, FSM states and PCM-to-duty conversion for the replay output stage
package audio_pkg;
  localparam int PCM_WIDTH = 16;
  localparam int PWM_BITS = 8;
  typedef logic signed [PCM_WIDTH-1:0] pcm_t;
  typedef logic [PWM_BITS-1:0] duty_t;
  localparam duty_t MIDSCALE = duty_t'(1 << (PWM_BITS - 1));
  typedef enum logic {DISABLED, RUN} state_t;
  function automatic duty_t pcm_to_duty(input pcm_t pcm);
    return {~pcm[PCM_WIDTH-1], pcm[PCM_WIDTH-2 -: PWM_BITS-1]};
  endfunction
endpackage

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo: show-ahead synchronous FIFO with flush (a same-cycle push survives the flush) and occupancy output
module pcm_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign level_o = cnt_q;
  assign data_o = mem_q[rd_ptr_q];
  // Pointer and occupancy update; flush discards old contents but keeps a concurrent push
  always_comb begin
    push_ok = push_i && (flush_i || !full_o);
    pop_ok = pop_i && !empty_o && !flush_i;
    wr_addr = flush_i ? '0 : wr_ptr_q;
    wr_ptr_d = wr_addr + AW'(push_ok);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop_ok);
    cnt_d = (flush_i ? '0 : cnt_q) + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  // Sample storage; contents need no reset because occupancy governs validity
  always_ff @(posedge clk_i)
    if (push_ok) mem_q[wr_addr] <= data_i;
  // Pointer and count registers
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pcm_pwm_modulator.sv
// pcm_pwm_modulator: buffers PCM samples and replays each for a fixed number of glitch-free PWM periods
module pcm_pwm_modulator
  import audio_pkg::*;
#(
  parameter int PERIODS_PER_SAMPLE = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic [PCM_WIDTH-1:0]        pcm_data_i,
  input  logic                        pcm_valid_i,
  output logic                        pcm_ready_o,
  output logic                        pwm_o,
  output logic                        audio_enable_o,
  output logic                        sample_tick_o,
  output logic                        underrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int SW = PERIODS_PER_SAMPLE > 1 ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(PERIODS_PER_SAMPLE - 1);
  state_t state_q, state_d;
  duty_t pwm_cnt_q, pwm_cnt_d, duty_q, duty_d, load_duty, cmp_duty;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic first_q, first_d, pwm_q, pwm_d, aen_q, aen_d, tick_q, tick_d, und_q, und_d;
  logic run, load, full, empty;
  logic [PCM_WIDTH-1:0] head;
  assign pcm_ready_o = enable_i && !full;
  assign pwm_o = pwm_q;
  assign audio_enable_o = aen_q;
  assign sample_tick_o = tick_q;
  assign underrun_o = und_q;
  pcm_sample_fifo #(.WIDTH(PCM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .flush_i(!run),
    .push_i(pcm_valid_i && pcm_ready_o),
    .pop_i(load),
    .data_i(pcm_data_i),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(fifo_level_o)
  );
  // Load detection, counters and next values of every registered output
  always_comb begin
    run = state_q == RUN;
    load = run && (first_q || (pwm_cnt_q == '1 && slot_cnt_q == SLOT_LAST));
    load_duty = empty ? MIDSCALE : pcm_to_duty(pcm_t'(head));
    cmp_duty = first_q ? load_duty : duty_q;
    state_d = enable_i ? RUN : DISABLED;
    pwm_cnt_d = run ? pwm_cnt_q + 1'b1 : '0;
    slot_cnt_d = !run ? '0 : pwm_cnt_q != '1 ? slot_cnt_q : slot_cnt_q == SLOT_LAST ? '0 : slot_cnt_q + 1'b1;
    duty_d = !run ? MIDSCALE : load ? load_duty : duty_q;
    first_d = !run;
    pwm_d = run && pwm_cnt_q < cmp_duty;
    aen_d = run;
    tick_d = load;
    und_d = load && empty && !first_q;
  end
  // FSM state, counters, held duty and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= DISABLED;
      pwm_cnt_q <= '0;
      slot_cnt_q <= '0;
      duty_q <= MIDSCALE;
      first_q <= 1'b1;
      pwm_q <= 1'b0;
      aen_q <= 1'b0;
      tick_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_cnt_q <= pwm_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      duty_q <= duty_d;
      first_q <= first_d;
      pwm_q <= pwm_d;
      aen_q <= aen_d;
      tick_q <= tick_d;
      und_q <= und_d;
    end
endmodule

// File: tb/tb_pcm_pwm_modulator.sv
// tb_pcm_pwm_modulator: sample-queue model checked every cycle plus directed scenarios with literal expectations
module tb_pcm_pwm_modulator;
  localparam int DEPTH = 8, PERIOD = 256, SLOT = 2048;
  logic clk = 0, rst_n = 0, enable = 0, pcm_valid = 0;
  logic [15:0] pcm_data = 0;
  logic pcm_ready, pwm, aen, tick, und;
  logic [3:0] level;
  int n_checks = 0, n_errors = 0;
  logic [15:0] m_q[$];
  bit m_run = 0, e_pwm = 0, e_aen = 0, e_tick = 0, e_und = 0, m_load, m_push;
  int m_k = 0, m_duty = 128, m_nd, m_dc;
  int hi, tk, ud;

  always #5 clk = ~clk;

  pcm_pwm_modulator #(.PERIODS_PER_SAMPLE(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pcm_data_i(pcm_data),
    .pcm_valid_i(pcm_valid), .pcm_ready_o(pcm_ready), .pwm_o(pwm),
    .audio_enable_o(aen), .sample_tick_o(tick), .underrun_o(und), .fifo_level_o(level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Offset-binary duty from the sample's value shifted into 0..65535
  function automatic int duty_of(input logic [15:0] s);
    return (int'($signed(s)) + 32768) / PERIOD;
  endfunction

  // Behavioural model: queue of samples, cycle index since the run began
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_q.delete();
      m_run = 0; m_k = 0; m_duty = 128;
      e_pwm = 0; e_aen = 0; e_tick = 0; e_und = 0;
    end else begin
      m_push = pcm_valid && enable && m_q.size() < DEPTH;
      if (!m_run) begin
        m_q.delete();
        e_pwm = 0; e_aen = 0; e_tick = 0; e_und = 0;
        m_k = 0; m_duty = 128;
      end else begin
        m_load = m_k == 0 || m_k % SLOT == SLOT - 1;
        e_tick = m_load; e_und = 0; m_nd = m_duty;
        if (m_load) begin
          if (m_q.size() > 0) m_nd = duty_of(m_q.pop_front());
          else begin m_nd = 128; e_und = m_k != 0; end
        end
        m_dc = m_k == 0 ? m_nd : m_duty;
        e_pwm = (m_k % PERIOD) < m_dc;
        m_duty = m_nd; e_aen = 1; m_k++;
      end
      if (m_push) m_q.push_back(pcm_data);
      m_run = enable;
    end

  // Per-cycle comparison against the model
  always @(negedge clk)
    if (rst_n) begin
      check("pwm_o", pwm, e_pwm);
      check("audio_enable_o", aen, e_aen);
      check("sample_tick_o", tick, e_tick);
      check("underrun_o", und, e_und);
      check("fifo_level_o", level, m_q.size());
      check("pcm_ready_o", pcm_ready, enable && m_q.size() < DEPTH);
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    @(negedge clk);
    for (int i = 0; i < 3000 && tick !== 1'b1; i++) @(negedge clk);
    check({name, "_tick_seen"}, tick, 1);
  endtask

  task automatic window(input int n, output int h, output int t, output int u);
    h = 0; t = 0; u = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      h += int'(pwm); t += int'(tick); u += int'(und);
    end
  endtask

  task automatic disable_run();
    step(1); enable = 0; step(4);
  endtask

  initial begin
    step(3); rst_n = 1;
    @(negedge clk);
    check("rst_pwm", pwm, 0); check("rst_aen", aen, 0); check("rst_tick", tick, 0);
    check("rst_und", und, 0); check("rst_level", level, 0); check("rst_ready", pcm_ready, 0);
    // No samples: silent midscale, underrun only after the first load
    step(1); enable = 1;
    wait_tick("empty");
    check("empty_first_und", und, 0);
    window(4096, hi, tk, ud);
    check("empty_high", hi, 2048); check("empty_und", ud, 2); check("empty_ticks", tk, 3);
    disable_run();
    // Zero sample queued before the first load
    enable = 1; pcm_valid = 1; pcm_data = 16'h0000;
    step(1); pcm_valid = 0;
    wait_tick("zero");
    window(2048, hi, tk, ud);
    check("zero_high", hi, 1024); check("zero_ticks", tk, 2); check("zero_und", ud, 1);
    @(negedge clk);
    window(2048, hi, tk, ud);
    check("zero_ticks2", tk, 1);
    disable_run();
    // Full scale then negative full scale
    enable = 1; pcm_valid = 1; pcm_data = 16'h7FFF;
    step(1); pcm_data = 16'h8000;
    step(1); pcm_valid = 0;
    wait_tick("fs");
    window(2048, hi, tk, ud);
    check("fs_max_high", hi, 2040); check("fs_max_und", ud, 0);
    @(negedge clk);
    window(2048, hi, tk, ud);
    check("fs_min_high", hi, 0); check("fs_min_und", ud, 1);
    disable_run();
    // Fill the FIFO and watch ready recover after one pop
    enable = 1;
    wait_tick("fill");
    step(1); pcm_valid = 1; pcm_data = 16'h1234;
    step(10);
    @(negedge clk);
    check("fill_level", level, 8); check("fill_ready", pcm_ready, 0);
    wait_tick("fill_pop");
    check("pop_level", level, 7); check("pop_ready", pcm_ready, 1);
    step(1); pcm_valid = 0;
    disable_run();
    // Disable mid-period with samples queued
    enable = 1;
    wait_tick("drop");
    step(1); pcm_valid = 1;
    for (int i = 0; i < 5; i++) begin pcm_data = 16'(i * 16'h2100); step(1); end
    pcm_valid = 0;
    step(93);
    @(negedge clk);
    check("drop_level_before", level, 5);
    step(1); enable = 0;
    step(2);
    @(negedge clk);
    check("drop_pwm", pwm, 0); check("drop_aen", aen, 0); check("drop_level", level, 0);
    step(1); enable = 1;
    wait_tick("reen");
    check("reen_und", und, 0);
    // Asynchronous reset mid-slot
    step(1); pcm_valid = 1; pcm_data = 16'hC000; step(2); pcm_valid = 0;
    step(300);
    #2 rst_n = 0;
    #1;
    check("arst_pwm", pwm, 0); check("arst_aen", aen, 0); check("arst_tick", tick, 0);
    check("arst_und", und, 0); check("arst_level", level, 0);
    step(3); rst_n = 1;
    wait_tick("post_rst");
    check("post_rst_und", und, 0);
    window(2048, hi, tk, ud);
    check("post_rst_high", hi, 1024);
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pcm_pwm_modulator.md
Name: pcm_pwm_modulator

Overview:
Replay-path output stage that consumes signed 16-bit PCM samples read back from sample memory and drives a 1-bit PWM audio pin plus the amplifier enable. Incoming samples are buffered in a small FIFO. Each sample is held for a fixed number of PWM periods, giving a constant output sample rate. Sits directly downstream of the sample-memory read path in the microphone top-level.

Parameters:
PCM_WIDTH, 16, PCM sample width (signed two's complement)
PWM_BITS, 8, PWM resolution; PWM period = 2^PWM_BITS clocks
PERIODS_PER_SAMPLE, 8, PWM periods per sample (power of 2, >=1); sample period = 2048 clocks at defaults
FIFO_DEPTH, 8, sample FIFO entries (power of 2)

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
enable_i  input  1  replay active; low flushes and silences the block
pcm_data_i  input  PCM_WIDTH  PCM sample
pcm_valid_i  input  1  sample valid
pcm_ready_o  output  1  FIFO can accept a sample
pwm_o  output  1  PWM audio output (registered)
audio_enable_o  output  1  amplifier enable (registered)
sample_tick_o  output  1  one-cycle pulse when a new duty is loaded
underrun_o  output  1  one-cycle pulse when a slot boundary finds the FIFO empty
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: pwm_o=0, audio_enable_o=0, sample_tick_o=0, underrun_o=0, fifo_level_o=0, FIFO empty, pwm counter=0, slot counter=0, duty=MIDSCALE, state=DISABLED.
- Reset asserted mid-operation clears everything immediately, including FIFO contents.
- pcm_ready_o = enable_i && !full (combinational). A push occurs when pcm_valid_i && pcm_ready_o.
- Duty conversion: duty = {~pcm[PCM_WIDTH-1], pcm[PCM_WIDTH-2 -: PWM_BITS-1]}, i.e. the top PWM_BITS bits converted to offset binary. MIDSCALE = 1 << (PWM_BITS-1) = 0x80.
- FSM DISABLED:
  - pwm_o=0, audio_enable_o=0, counters held at 0, FIFO flushed every cycle, duty=MIDSCALE.
  - enable_i=1 -> RUN.
- FSM RUN:
  - audio_enable_o=1.
  - pwm_cnt increments every cycle and wraps 2^PWM_BITS-1 -> 0. slot_cnt increments on each pwm_cnt wrap.
  - pwm_o(next) = (pwm_cnt < duty). Duty 0 gives always low; duty 255 gives 255 of 256 cycles high.
- Load event:
  - Occurs on the first RUN cycle and on each cycle where pwm_cnt = max and slot_cnt = PERIODS_PER_SAMPLE-1.
  - The new duty takes effect for the comparison at pwm_cnt=0. Duty never changes mid-period, so the output is glitch-free.
  - If the FIFO is non-empty: pop, duty = converted head, sample_tick_o=1.
  - If the FIFO is empty: duty = MIDSCALE, sample_tick_o=1, underrun_o=1. Exception: no underrun pulse is raised on the first RUN load.
- Simultaneous push and pop on an empty FIFO: the pop sees empty, so underrun is raised. The pushed sample is stored and used at the next slot (no bypass).
- Simultaneous push and pop on a non-empty FIFO: level is unchanged.
- Full FIFO: ready is low, so no push is possible even if a pop occurs that same cycle.
- enable_i dropping in RUN:
  - Next cycle goes to DISABLED; pwm_o=0 and audio_enable_o=0 one cycle later.
  - The FIFO is flushed, and a partial period is truncated.
- Re-enable restarts from pwm_cnt=0 with a fresh first load.

Decomposition:
- audio_pkg:
  - PCM_WIDTH and MIDSCALE constants
  - pcm_t typedef
  - duty_t typedef
  - pcm_to_duty() function
  - FSM state enum {DISABLED, RUN}
- Sub-module pcm_sample_fifo:
  - synchronous FIFO with flush input and level output
  - show-ahead head read
  - contains no pointer logic shared with the modulator

Test Plan:
- Enable, push 0x0000 before the first load -> duty 0x80; pwm_o high 128 of every 256 cycles for 2048 cycles; sample_tick_o pulses once per 2048 cycles.
- Push 0x7FFF then 0x8000 -> first slot pwm_o high 255/256 cycles; second slot pwm_o constantly 0; duty switches only at pwm_cnt=0.
- Enable with no samples, wait 2 slots -> no underrun on the first load, underrun_o pulses at cycle 2048 and 4096; pwm_o stays at 50% duty.
- Hold pcm_valid_i high with no pops -> 8 pushes accepted, fifo_level_o=8, pcm_ready_o=0; after the next load level=7 and ready returns to 1.
- Drop enable_i at pwm_cnt=100 with 5 samples queued -> pwm_o=0 and audio_enable_o=0 within 2 cycles, fifo_level_o=0; re-enable gives a fresh first load with no underrun.
- Assert rst_n_i low mid-slot, asynchronously -> all outputs 0 immediately, FIFO empty; operation resumes cleanly after release.
